// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants and types for the 4-digit BCD display scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}; anodes are active-low.
package bcd_disp_pkg;

    // Index of the digit slot currently being driven (0 = units).
    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_ALL_OFF = 4'b1111;

    // Active-low one-hot anode pattern for a digit slot.
    function automatic logic [3:0] an_select(digit_idx_t idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Digit inputs and display pins of the BCD display scanner.
// master: digit source / board side; slave: the scanner itself.
interface bcd_display_scanner_if;

    logic [3:0] BCD3;
    logic [3:0] BCD2;
    logic [3:0] BCD1;
    logic [3:0] BCD0;
    logic [3:0] AN;
    logic [6:0] SEG;
    logic       FRAME;

    modport master (
        output BCD3, BCD2, BCD1, BCD0,
        input  AN, SEG, FRAME
    );

    modport slave (
        input  BCD3, BCD2, BCD1, BCD0,
        output AN, SEG, FRAME
    );

endinterface

// File: rtl/bcd_display_scanner_seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Ports: bcd (4-bit digit in), seg (7-bit {g..a} out); 10..15 give a dash.
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        unique case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 4-digit common-anode 7-seg driver with per-frame snapshot.
// Ports: Clock, Clear (sync, active-high), bus (slave: BCD3..0 in; AN, SEG,
// FRAME out, all registered). Optional macro LEADING_ZERO_BLANK_EN blanks
// leading zero digits (units digit always shown).
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 1
) (
    input  logic                 Clock,
    input  logic                 Clear,
    bcd_display_scanner_if.slave bus
);

    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0]   prescaler;
    logic [PW-1:0]   prescaler_n;
    digit_idx_t      idx;
    digit_idx_t      idx_n;
    logic [3:0][3:0] snap;
    logic [3:0][3:0] snap_n;

    logic [3:0] an_q;
    logic [6:0] seg_q;
    logic       frame_q;

    logic [3:0] an_d;
    logic [6:0] seg_d;
    logic       frame_d;

    logic       last_tick;
    logic       frame_end;
    logic       in_guard;
    logic [3:0] blank;
    logic       cur_blank;
    logic [6:0] seg_dec;

    assign last_tick = (prescaler == PW'(REFRESH_DIV - 1));
    assign frame_end = last_tick && (idx == 2'd3);

    // Anodes stay dark for the first few clocks of each slot so the
    // segment lines can settle before the next digit lights (anti-ghost).
    if (GUARD_CYCLES > 0) begin : g_guard
        assign in_guard = (prescaler < PW'(GUARD_CYCLES));
    end else begin : g_noguard
        assign in_guard = 1'b0;
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank only if it and every more-significant digit are
    // zero; invalid codes count as nonzero so they stay visible as dashes.
    always_comb begin
        blank    = 4'b0000;
        blank[3] = (snap[3] == 4'd0);
        blank[2] = blank[3] && (snap[2] == 4'd0);
        blank[1] = blank[2] && (snap[1] == 4'd0);
        blank[0] = 1'b0;
    end
`else
    assign blank = 4'b0000;
`endif

    assign cur_blank = blank[idx];

    bcd_to_7seg u_dec (
        .bcd (snap[idx]),
        .seg (seg_dec)
    );

    // Next-state: prescaler wraps per slot, idx advances on wrap, and all
    // four digits are captured together at the frame boundary.
    always_comb begin
        prescaler_n = prescaler + PW'(1);
        idx_n       = idx;
        snap_n      = snap;
        if (last_tick) begin
            prescaler_n = '0;
            idx_n       = idx + 2'd1;
        end
        if (frame_end) begin
            snap_n = {bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0};
        end
    end

    // Output decode from the current scan state; registered below.
    always_comb begin
        an_d    = an_select(idx);
        seg_d   = seg_dec;
        frame_d = frame_end;
        if (in_guard || cur_blank) begin
            an_d = AN_ALL_OFF;
        end
        if (cur_blank) begin
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            prescaler <= '0;
            idx       <= '0;
            snap      <= '0;
            an_q      <= AN_ALL_OFF;
            seg_q     <= SEG_BLANK;
            frame_q   <= 1'b0;
        end else begin
            prescaler <= prescaler_n;
            idx       <= idx_n;
            snap      <= snap_n;
            an_q      <= an_d;
            seg_q     <= seg_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.AN    = an_q;
    assign bus.SEG   = seg_q;
    assign bus.FRAME = frame_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner (REFRESH_DIV=4, GUARD_CYCLES=1).
// Table of digit sets with hand-computed segment codes plus hand sequences.
module tb_bcd_display_scanner;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    // d: {BCD3,BCD2,BCD1,BCD0}; s: expected SEG per slot; vis: slot lit
    typedef struct packed {
        logic [3:0][3:0] d;
        logic [3:0][6:0] s;
        logic [3:0]      vis;
    } vec_t;

    localparam int NV = 7;

    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl [NV];
    vec_t va;
    vec_t vb;
    vec_t vz;

    always #5 clk = ~clk;

    bcd_display_scanner_if bus ();

    bcd_display_scanner #(
        .REFRESH_DIV  (4),
        .GUARD_CYCLES (1)
    ) dut (
        .Clock (clk),
        .Clear (clr),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [6:0] act, logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic set_in(logic [3:0][3:0] d);
        bus.BCD3 = d[3];
        bus.BCD2 = d[2];
        bus.BCD1 = d[1];
        bus.BCD0 = d[0];
    endtask

    // Walk one 4-cycle slot, checking AN/SEG/FRAME each cycle.
    task automatic check_slot(int slot, vec_t v, string tag);
        logic [3:0] one;
        logic [3:0] ea;
        logic [6:0] es;
        logic       ef;
        one = 4'b0001;
        for (int p = 0; p < 4; p++) begin
            tick();
            ea = (p == 0 || !v.vis[slot]) ? 4'b1111 : ~(one << slot);
            es = v.vis[slot] ? v.s[slot] : 7'b1111111;
            ef = (slot == 3 && p == 3);
            chk($sformatf("%s an s%0d p%0d", tag, slot, p),
                {3'b000, bus.AN}, {3'b000, ea});
            chk($sformatf("%s seg s%0d p%0d", tag, slot, p), bus.SEG, es);
            chk($sformatf("%s frame s%0d p%0d", tag, slot, p),
                {6'd0, bus.FRAME}, {6'd0, ef});
        end
    endtask

    task automatic check_frame(vec_t v, string tag);
        for (int s = 0; s < 4; s++) begin
            check_slot(s, v, tag);
        end
    endtask

    task automatic check_reset(string tag);
        chk({tag, " an"}, {3'b000, bus.AN}, 7'b0001111);
        chk({tag, " seg"}, bus.SEG, 7'b1111111);
        chk({tag, " frame"}, {6'd0, bus.FRAME}, 7'd0);
    endtask

    initial begin
        tbl[0] = '{d: {4'd1, 4'd2, 4'd3, 4'd4}, s: {S1, S2, S3, S4},
                   vis: 4'b1111};
        tbl[1] = '{d: {4'd0, 4'd0, 4'd0, 4'd7}, s: {S0, S0, S0, S7},
                   vis: LZB ? 4'b0001 : 4'b1111};
        tbl[2] = '{d: {4'd0, 4'hC, 4'd0, 4'd0}, s: {S0, SD, S0, S0},
                   vis: LZB ? 4'b0111 : 4'b1111};
        tbl[3] = '{d: {4'd9, 4'd8, 4'd6, 4'd5}, s: {S9, S8, S6, S5},
                   vis: 4'b1111};
        tbl[4] = '{d: {4'd0, 4'd0, 4'd0, 4'd0}, s: {S0, S0, S0, S0},
                   vis: LZB ? 4'b0001 : 4'b1111};
        tbl[5] = '{d: {4'd0, 4'd0, 4'hF, 4'd0}, s: {S0, S0, SD, S0},
                   vis: LZB ? 4'b0011 : 4'b1111};
        tbl[6] = '{d: {4'd0, 4'd5, 4'd0, 4'd0}, s: {S0, S5, S0, S0},
                   vis: LZB ? 4'b0111 : 4'b1111};
        va = '{d: {4'd1, 4'd2, 4'd3, 4'd5}, s: {S1, S2, S3, S5},
               vis: 4'b1111};
        vb = '{d: {4'd1, 4'd2, 4'd3, 4'd6}, s: {S1, S2, S3, S6},
               vis: 4'b1111};
        vz = tbl[4];

        clr = 1'b1;
        set_in(vz.d);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset($sformatf("reset%0d", i));
        end
        clr = 1'b0;
        set_in(tbl[0].d);
        check_frame(vz, "first");

        for (int i = 0; i < NV; i++) begin
            set_in((i + 1 < NV) ? tbl[i + 1].d : tbl[i].d);
            check_frame(tbl[i], $sformatf("vec%0d", i));
        end

        set_in(va.d);
        check_frame(tbl[NV - 1], "hold");
        check_slot(0, va, "mid");
        check_slot(1, va, "mid");
        set_in(vb.d);
        check_slot(2, va, "mid");
        check_slot(3, va, "mid");
        check_slot(0, vb, "new");
        check_slot(1, vb, "new");

        tick();
        chk("clr guard an", {3'b000, bus.AN}, 7'b0001111);
        tick();
        chk("clr slot2 an", {3'b000, bus.AN}, 7'b0001011);
        chk("clr slot2 seg", bus.SEG, S2);
        clr = 1'b1;
        tick();
        check_reset("midclr");
        clr = 1'b0;
        check_frame(vz, "restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
